// File: rtl/dm_arbiter_if.sv
// Request/response bus for the two data-memory requesters plus the memory-side port.
// The arbiter takes the slave modport; the environment (requesters + memory) takes the master modport.
interface dm_arbiter_if;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic        req0_we,    req1_we;
   logic [31:0] req0_addr,  req1_addr;
   logic [31:0] req0_wdata, req1_wdata;
   logic [3:0]  req0_be,    req1_be;
   logic [31:0] req0_pc,    req1_pc;
   logic        resp0_valid, resp1_valid;
   logic [31:0] resp0_rdata, resp1_rdata;
   logic        resp0_err,   resp1_err;
   logic [31:0] mem_addr, mem_wdata, mem_pc, mem_rdata;
   logic        mem_we;

   modport slave (
      input  req0_valid, req1_valid, req0_we, req1_we, req0_addr, req1_addr,
             req0_wdata, req1_wdata, req0_be, req1_be, req0_pc, req1_pc, mem_rdata,
      output req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_rdata, resp1_rdata,
             resp0_err, resp1_err, mem_addr, mem_wdata, mem_we, mem_pc
   );

   modport master (
      output req0_valid, req1_valid, req0_we, req1_we, req0_addr, req1_addr,
             req0_wdata, req1_wdata, req0_be, req1_be, req0_pc, req1_pc, mem_rdata,
      input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_rdata, resp1_rdata,
             resp0_err, resp1_err, mem_addr, mem_wdata, mem_we, mem_pc
   );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port arbiter and access sequencer for the word-write-only data memory.
// Byte-enabled partial writes are turned into a read-modify-write over two memory cycles.
module dm_arbiter #(
   parameter int unsigned DEPTH      = 1024,
   parameter bit          FIXED_PRIO = 1'b0
) (
   input logic         clk,
   input logic         reset,
   dm_arbiter_if.slave bus
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_ACCESS   = 2'd1;
   localparam logic [1:0] S_MERGE_WR = 2'd2;
   localparam logic [1:0] S_RESP     = 2'd3;

   localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

   logic [1:0]  state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic        port_q, port_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] merged_q, merged_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        win1, ready0, ready1;
   logic        in_range, full_wr, partial_wr, mem_active;
   logic [31:0] mask;

   // When both request, round-robin favours the port that did not win last time.
   always_comb begin
      if (FIXED_PRIO)
         win1 = bus.req1_valid && !bus.req0_valid;
      else if (bus.req0_valid && bus.req1_valid)
         win1 = !last_grant_q;
      else
         win1 = bus.req1_valid;
   end

   assign ready0 = reset && (state_q == S_IDLE) && bus.req0_valid && !win1;
   assign ready1 = reset && (state_q == S_IDLE) && bus.req1_valid && win1;
   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;

   always_comb begin
      mask = '0;
      for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{be_q[i]}};
   end

   assign in_range   = addr_q < ADDR_LIMIT;
   assign full_wr    = be_q == 4'hF;
   assign partial_wr = (be_q != 4'h0) && !full_wr;

   // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      port_d       = port_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      pc_d         = pc_q;
      merged_d     = merged_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      case (state_q)
         S_IDLE: begin
            if (ready0 || ready1) begin
               port_d       = ready1;
               last_grant_d = ready1;
               we_d         = ready1 ? bus.req1_we    : bus.req0_we;
               addr_d       = ready1 ? bus.req1_addr  : bus.req0_addr;
               wdata_d      = ready1 ? bus.req1_wdata : bus.req0_wdata;
               be_d         = ready1 ? bus.req1_be    : bus.req0_be;
               pc_d         = ready1 ? bus.req1_pc    : bus.req0_pc;
               state_d      = S_ACCESS;
            end
         end
         S_ACCESS: begin
            rdata_d = '0;
            err_d   = 1'b0;
            state_d = S_RESP;
            if (!in_range) begin
               err_d = 1'b1;
            end else if (!we_q) begin
               rdata_d = bus.mem_rdata;
            end else if (partial_wr) begin
               merged_d = (bus.mem_rdata & ~mask) | (wdata_q & mask);
               state_d  = S_MERGE_WR;
            end
         end
         S_MERGE_WR: state_d = S_RESP;
         default:    state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         port_q       <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         pc_q         <= '0;
         merged_q     <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         port_q       <= port_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         pc_q         <= pc_d;
         merged_q     <= merged_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
      end
   end

   // Memory-side outputs are pure decodes of state, so a reset clears them within the same cycle.
   assign mem_active    = (state_q == S_ACCESS) || (state_q == S_MERGE_WR);
   assign bus.mem_addr  = mem_active ? {addr_q[31:2], 2'b00} : 32'd0;
   assign bus.mem_pc    = mem_active ? pc_q : 32'd0;
   assign bus.mem_we    = ((state_q == S_ACCESS) && in_range && we_q && full_wr) ||
                          (state_q == S_MERGE_WR);
   assign bus.mem_wdata = (state_q == S_MERGE_WR) ? merged_q :
                          ((state_q == S_ACCESS) && in_range && we_q && full_wr) ? wdata_q : 32'd0;

   assign bus.resp0_valid = (state_q == S_RESP) && !port_q;
   assign bus.resp1_valid = (state_q == S_RESP) && port_q;
   assign bus.resp0_rdata = bus.resp0_valid ? rdata_q : 32'd0;
   assign bus.resp1_rdata = bus.resp1_valid ? rdata_q : 32'd0;
   assign bus.resp0_err   = bus.resp0_valid && err_q;
   assign bus.resp1_err   = bus.resp1_valid && err_q;

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter and access sequencer in front of the 1024-word data memory.
- Requester 0 is the CPU MEM stage; requester 1 is the debug/DMA loader. Either port can do word reads, word writes and byte-enabled partial writes.
- Partial writes become read-modify-write sequences, because the memory only supports full-word writes and combinational reads.
- Sits between the pipeline MEM stage and the data memory. Drives the memory address, write data, write enable and trace PC.

Parameters:
- DEPTH, 1024, memory depth in words; byte addresses at or above DEPTH*4 are out of range.
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0_valid, req1_valid  in  1  request present.
- req0_ready, req1_ready  out  1  request accepted this cycle (valid && ready = handshake).
- req0_we, req1_we  in  1  1 = write, 0 = read.
- req0_addr, req1_addr  in  32  byte address; bits [1:0] ignored.
- req0_wdata, req1_wdata  in  32  write data, already lane-aligned.
- req0_be, req1_be  in  4  byte enables; be[i] covers bits [8i+7:8i].
- req0_pc, req1_pc  in  32  PC for the write trace.
- resp0_valid, resp1_valid  out  1  one-cycle completion pulse.
- resp0_rdata, resp1_rdata  out  32  read data, valid with resp_valid; 0 for writes.
- resp0_err, resp1_err  out  1  out-of-range access, valid with resp_valid.
- mem_addr  out  32  address to memory; {20'b0, word_index, 2'b00}.
- mem_wdata  out  32  write data to memory.
- mem_we  out  1  memory write enable.
- mem_pc  out  32  trace PC to memory.
- mem_rdata  in  32  combinational read data from memory.

Behaviour:
- States: IDLE, ACCESS, MERGE_WR, RESP.
- Reset (asynchronous, active-low), immediately while reset = 0:
  - state = IDLE, last_grant = 1.
  - All outputs 0: ready, resp_valid, rdata, err, mem_we, mem_addr, mem_wdata, mem_pc.
  - An in-flight request is dropped with no response and no further mem_we.
- IDLE:
  - ready is combinational. Only the winning valid port gets ready = 1; at most one ready high per cycle.
  - Winner with FIXED_PRIO = 0: the port not equal to last_grant when both are valid; otherwise the sole valid port.
  - On handshake, latch port id, we, addr, wdata, be and pc; set last_grant = winner; go to ACCESS.
- ACCESS (ready = 0):
  - mem_addr = latched address with bits [1:0] = 0.
  - Out of range (addr >= DEPTH*4): mem_we = 0; set err = 1, rdata = 0; go to RESP.
  - Read: capture mem_rdata; go to RESP.
  - Write with be = 4'hF: mem_we = 1, mem_wdata = latched wdata, mem_pc = latched pc; go to RESP.
  - Write with be = 0: no mem_we; go to RESP.
  - Other write: capture merged = (mem_rdata & ~mask) | (wdata & mask), where mask expands be to 32 bits; mem_we = 0; go to MERGE_WR.
- MERGE_WR: mem_we = 1, mem_wdata = merged, same mem_addr and mem_pc; go to RESP.
- RESP:
  - respN_valid = 1 for the latched port only, for exactly one cycle, with rdata and err.
  - The other port's resp outputs stay 0. Go to IDLE.
- mem_we, mem_addr, mem_wdata and mem_pc are decoded from state and latch registers. They are stable for the whole cycle; mem_we is never high in IDLE or RESP.
- Latency from handshake cycle T:
  - Read and full write: memory access at T+1, response at T+2.
  - Partial write: mem_we at T+2, response at T+3.
- Throughput: the next request can be accepted in the cycle after RESP. Minimum spacing is 3 cycles for full accesses, 4 for partial writes.
- A requester must hold valid and all request fields stable until it sees ready. Dropping valid before ready is allowed and cancels the request.
- The port not granted sees ready = 0 and keeps waiting. Round-robin guarantees service within one other transaction.

Test Plan:
- Reset, then req0 read at 0x10 with memory word = 0xDEADBEEF -> req0_ready at T; mem_addr = 0x10 at T+1; resp0_valid = 1 with rdata 0xDEADBEEF at T+2 only; resp1_valid stays 0.
- req1 write to 0x20 with wdata 0x12345678, be 4'hF -> mem_we = 1 only at T+1, mem_addr 0x20, mem_pc = req1_pc; resp1_valid at T+2 with rdata 0 and err 0.
- Partial write: word 0xAABBCCDD at 0x40; req0 write wdata 0x0000EE00, be 4'b0010 -> no mem_we at T+1; mem_we at T+2 with mem_wdata 0xAABBEEDD; resp0_valid at T+3.
- Both valid continuously after reset, FIXED_PRIO = 0 -> grants alternate 0, 1, 0, 1 across four transactions. Repeat with FIXED_PRIO = 1 -> port 0 granted every time while valid.
- req0 read at 0x1000 (DEPTH = 1024) -> mem_we stays 0; resp0_valid with err = 1, rdata = 0 at T+2. A write to 0xFFFC leaves memory unchanged.
- Assert reset = 0 during MERGE_WR -> mem_we drops to 0 in the same cycle, no resp pulse. After release, all outputs are 0, state is IDLE, and the next req0 is granted first.
